clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Clock-gating controller that drives the enable of a downstream integrated clock-gating cell (ICG) for one gated clock domain. It sequences the domain on when any requester, in-flight work or a software override needs it. It gates the domain off after a programmable idle window. A ready handshake guarantees requesters never issue work while the gated clock is stopped or still settling.

## Interface
- NUM_REQ, 4, number of independent requesters sharing the gated domain (>=1)
- IDLE_CYCLES, 16, consecutive inactive cycles required before gating off (>=1)
- WAKE_CYCLES, 2, cycles clk_en is held high before ready asserts (>=1)
- WCNT_W, 16, width of the wake statistics counter

- clk  input  1  free-running source clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- req  input  NUM_REQ  per-requester demand for the gated domain
- busy  input  1  gated domain has in-flight work
- force_on  input  1  software override that keeps the domain clocked
- clk_en  output  1  registered enable to the ICG; gated clock = clk & clk_en
- ready  output  1  gated clock is stable; requesters may issue work
- gated  output  1  status, high while in OFF
- wake_count  output  WCNT_W  saturating count of OFF->WAKE transitions

## Operation
- Activity: act = |req | busy | force_on, sampled each posedge.
- State OFF
  - Outputs: clk_en=0, ready=0, gated=1.
  - act -> WAKE; wake_count increments, saturating at all-ones.
- State WAKE
  - Outputs: clk_en=1, ready=0, gated=0.
  - wake_cnt counts 0..WAKE_CYCLES-1, then -> ON.
  - act is ignored during WAKE.
- State ON
  - Outputs: clk_en=1, ready=1, gated=0.
  - idle_cnt is cleared on act and incremented on !act.
  - !act with idle_cnt==IDLE_CYCLES-1 -> PREOFF.
- State PREOFF
  - Outputs: clk_en=1, ready=0, gated=0. Lasts one cycle.
  - Purpose: requesters observe ready low one full cycle before the clock stops.
  - act -> ON, with idle_cnt cleared.
  - !act -> OFF.
- Register rules
  - All outputs are registered, decoded from the state register only.
  - clk_en changes only at posedge clk, so the ICG sees a glitch-free enable.
- Invariants
  - clk_en==0 implies ready==0.
  - ready never rises without at least WAKE_CYCLES cycles of clk_en==1 directly before it.
- Reset
  - While rst is high at a posedge: state=OFF, clk_en=0, ready=0, gated=1, idle_cnt=0, wake_cnt=0, wake_count=0.
  - Reset applies from any state, including WAKE and PREOFF.
  - The first post-reset decision is taken on the first posedge with rst low.
- force_on or busy held high keeps the controller in ON indefinitely.
- req may drop while busy is high; gating waits for busy to fall.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

## Timing
- Wake latency: act sampled at edge t (state OFF)
  - clk_en=1 from edge t+1.
  - ready=1 from edge t+1+WAKE_CYCLES.
- Gate-off latency: first inactive cycle sampled at edge k in ON, with no act through edge k+IDLE_CYCLES
  - ready=0 from edge k+IDLE_CYCLES (PREOFF).
  - clk_en=0 from edge k+IDLE_CYCLES+1.
- Rescue from PREOFF: act at the PREOFF edge returns ready=1 on the next edge; clk_en never drops.
- Simultaneous events
  - Activity and idle-count expiry in the same cycle: activity wins, stay ON.
  - rst overrides all inputs.

## Test plan
Parameters for all scenarios: IDLE_CYCLES=4, WAKE_CYCLES=2, WCNT_W=2, NUM_REQ=4.
- Cold wake: reset, then req=4'b0001 sampled at edge 0 -> clk_en=1 at edge 1, ready=1 at edge 3, gated=0, wake_count=1.
- Idle gate-off: from ON, req=0, busy=0, force_on=0 first sampled at edge k -> ready=0 at k+4, clk_en=0 at k+5, gated=1 at k+5; ready never high while clk_en low.
- PREOFF rescue: req[2] pulsed for one cycle at the PREOFF edge -> ready=1 next edge, clk_en stays 1 throughout, wake_count unchanged.
- Hold-on: req=0, busy=1 for 20 cycles, then force_on=1 for 20 cycles -> clk_en=1 and ready=1 throughout; after both drop, gate-off follows the 4+1 cycle timing.
- Reset mid-WAKE: rst=1 sampled one edge after clk_en rises -> next edge clk_en=0, ready=0, gated=1, wake_count=0; a new req re-wakes with full WAKE_CYCLES latency.
- Saturation: five complete wake/gate-off cycles -> wake_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/clk_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl_if
// Brief    : Requester/controller bundle for the clock-gating controller.
// Revision : 1.0 - initial release
// ============================================================================
interface clk_gate_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int WCNT_W  = 16
) ();
    logic [NUM_REQ-1:0] req;
    logic               busy;
    logic               force_on;
    logic               clk_en;
    logic               ready;
    logic               gated;
    logic [WCNT_W-1:0]  wake_count;

    // Requester / software side: drives demand, observes enable and status.
    modport master (
        output req,
        output busy,
        output force_on,
        input  clk_en,
        input  ready,
        input  gated,
        input  wake_count
    );

    // Controller side.
    modport slave (
        input  req,
        input  busy,
        input  force_on,
        output clk_en,
        output ready,
        output gated,
        output wake_count
    );
endinterface
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : ICG enable sequencer with wake settling, idle gate-off and
//            one-cycle ready-low warning before the clock stops.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int WCNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    clk_gate_ctrl_if.slave  bus
);

    localparam int c_IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int c_WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [c_WAKE_W-1:0] c_WAKE_LAST = c_WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ON     = 2'd2,
        ST_PREOFF = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [c_WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [WCNT_W-1:0]   wake_count_q, wake_count_d;
    logic                clk_en_q, clk_en_d;
    logic                ready_q, ready_d;
    logic                gated_q, gated_d;
    logic                w_act;

    assign w_act = (|bus.req) | bus.busy | bus.force_on;

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        wake_cnt_d   = wake_cnt_q;
        wake_count_d = wake_count_q;

        case (state_q)
            ST_OFF: begin
                idle_cnt_d = '0;
                wake_cnt_d = '0;
                if (w_act) begin
                    state_d = ST_WAKE;
                    if (wake_count_q != {WCNT_W{1'b1}}) begin
                        wake_count_d = wake_count_q + 1'b1;
                    end
                end
            end
            ST_WAKE: begin
                // Activity is irrelevant here: the clock must settle regardless.
                idle_cnt_d = '0;
                if (wake_cnt_q == c_WAKE_LAST) begin
                    state_d    = ST_ON;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            ST_ON: begin
                wake_cnt_d = '0;
                if (w_act) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == c_IDLE_LAST) begin
                    state_d    = ST_PREOFF;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_PREOFF: begin
                idle_cnt_d = '0;
                wake_cnt_d = '0;
                state_d    = w_act ? ST_ON : ST_OFF;
            end
            default: begin
                state_d    = ST_OFF;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change only on posedge
    // and line up exactly with the state register.
    always_comb begin
        clk_en_d = (state_d != ST_OFF);
        ready_d  = (state_d == ST_ON);
        gated_d  = (state_d == ST_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            idle_cnt_q   <= '0;
            wake_cnt_q   <= '0;
            wake_count_q <= '0;
            clk_en_q     <= 1'b0;
            ready_q      <= 1'b0;
            gated_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            wake_cnt_q   <= wake_cnt_d;
            wake_count_q <= wake_count_d;
            clk_en_q     <= clk_en_d;
            ready_q      <= ready_d;
            gated_q      <= gated_d;
        end
    end

    assign bus.clk_en     = clk_en_q;
    assign bus.ready      = ready_q;
    assign bus.gated      = gated_q;
    assign bus.wake_count = wake_count_q;

    a_ready_needs_clk : assert property (@(posedge clk) disable iff (rst)
        !clk_en_q |-> !ready_q);

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Brief    : Directed scoreboard bench for clk_gate_ctrl (IDLE=4, WAKE=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    typedef struct packed {
        logic       ce;
        logic       rdy;
        logic       g;
        logic [1:0] wc;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    clk_gate_ctrl_if #(.NUM_REQ(4), .WCNT_W(2)) bus ();

    clk_gate_ctrl #(
        .NUM_REQ     (4),
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2),
        .WCNT_W      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (bus.clk_en === e.ce) else begin
            n_err++;
            $error("FAIL %s clk_en: observed %b expected %b", t, bus.clk_en, e.ce);
        end
        n_cmp++;
        assert (bus.ready === e.rdy) else begin
            n_err++;
            $error("FAIL %s ready: observed %b expected %b", t, bus.ready, e.rdy);
        end
        n_cmp++;
        assert (bus.gated === e.g) else begin
            n_err++;
            $error("FAIL %s gated: observed %b expected %b", t, bus.gated, e.g);
        end
        n_cmp++;
        assert (bus.wake_count === e.wc) else begin
            n_err++;
            $error("FAIL %s wake_count: observed %0d expected %0d", t, bus.wake_count, e.wc);
        end
        n_cmp++;
        assert ((bus.clk_en | ~bus.ready) === 1'b1) else begin
            n_err++;
            $error("FAIL %s ready_while_gated: observed clk_en=%b ready=%b expected ready=0",
                   t, bus.clk_en, bus.ready);
        end
    endtask

    // Drive inputs sampled at the next posedge; expect the outputs seen at the one after.
    task automatic step(input string tag, input logic r_rst, input logic [3:0] r,
                        input logic b, input logic f, input logic ce, input logic rdy,
                        input logic g, input logic [1:0] wc);
        exp_t e;
        rst          = r_rst;
        bus.req      = r;
        bus.busy     = b;
        bus.force_on = f;
        e.ce  = ce;
        e.rdy = rdy;
        e.g   = g;
        e.wc  = wc;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        check();
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        step(tag, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic wake(input string tag, input logic [1:0] wc);
        step(tag, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, wc);
        step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, wc);
        step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, wc);
    endtask

    task automatic idle_on(input string tag, input int n, input logic [1:0] wc);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, wc);
    endtask

    task automatic gate_off(input string tag, input logic [1:0] wc);
        idle_on(tag, 3, wc);
        step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, wc);
        step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wc);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.req      = '0;
        bus.busy     = 1'b0;
        bus.force_on = 1'b0;
        @(negedge clk);

        do_reset("reset");
        step("off_idle", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        wake("cold_wake", 2'd1);
        gate_off("idle_off", 2'd1);

        // Activity coinciding with idle expiry keeps the domain on.
        wake("wake2", 2'd2);
        idle_on("pre_expiry", 3, 2'd2);
        step("act_at_expiry", 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        idle_on("after_expiry", 3, 2'd2);
        step("enter_preoff", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        step("preoff_rescue", 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        gate_off("post_rescue_off", 2'd2);

        wake("wake3", 2'd3);
        step("busy_with_req", 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 20; i++)
            step("hold_busy", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 20; i++)
            step("hold_force", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3);
        gate_off("hold_release_off", 2'd3);

        step("wake_sat", 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        step("rst_mid_wake", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        wake("rewake", 2'd1);
        gate_off("rewake_off", 2'd1);

        do_reset("reset2");
        for (int i = 1; i <= 5; i++) begin
            wake("sat_wake", (i > 3) ? 2'd3 : 2'(i));
            gate_off("sat_off", (i > 3) ? 2'd3 : 2'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
